lzw_dict_ctrl: RTL and testbench
================================

# lzw_dict_ctrl

Sequencer for the LZW dictionary lookup and insert path. Accepts one (key, hash) request at a time and probes the primary hash RAM. On a slot collision it probes the 8-entry conflict table. On a miss it allocates the next code and writes it into the hash RAM, or into the conflict table if the slot is occupied. It sits between the compressor front end and the hash RAM / conflict table pair, and is their only master.

## Interface
- DATA_WIDTH, 64, key width (prefix code + byte, nonzero by construction)
- HASH_WIDTH, 12, hash RAM address width and code width
- FIRST_CODE, 256, first allocatable code
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  high only in IDLE
- req_key  in  DATA_WIDTH  key
- req_hash  in  HASH_WIDTH  precomputed hash of key
- resp_valid  out  1  response available
- resp_ready  in  1  response accepted
- resp_hit  out  1  key was found
- resp_code  out  HASH_WIDTH  found code, or newly allocated code
- resp_new  out  1  key was inserted this request
- resp_overflow  out  1  miss but no insert (dictionary full or CT full)
- ram_en, ram_we  out  1  hash RAM strobe / write
- ram_addr  out  HASH_WIDTH  hash RAM address
- ram_wkey / ram_rkey  out / in  DATA_WIDTH  stored key
- ram_wcode / ram_rcode  out / in  HASH_WIDTH  stored code
- ram_wvld / ram_rvld  out / in  1  slot-occupied flag
- ct_cs, ct_we  out  1  conflict table select / write
- ct_data  out  DATA_WIDTH  CT key
- ct_hash  out  HASH_WIDTH  CT hash
- ct_map  out  HASH_WIDTH  CT code
- ct_match  in  1  combinational match
- ct_map_out  in  HASH_WIDTH  registered code
- ct_full  in  1  CT full
- dict_full  out  1  code counter exhausted

## Operation
- Request capture: req_key and req_hash are registered on req_valid & req_ready. Inputs are ignored outside IDLE.
- States: IDLE, RAM_RD, RAM_CHK, CT_Q, CT_RD, INSERT, RESP.
- IDLE → RAM_RD on accept.
- RAM_RD: ram_en=1, ram_we=0, ram_addr=hash. Always → RAM_CHK.
- RAM_CHK (RAM data valid, 1-cycle read latency):
  - ram_rvld & ram_rkey==key → RESP with hit, code=ram_rcode.
  - ram_rvld & key mismatch → CT_Q.
  - !ram_rvld → INSERT into RAM.
- CT_Q: ct_cs=1, ct_we=0, ct_data=key. Sample ct_match this cycle. → CT_RD.
- CT_RD: hold ct_cs=1, ct_we=0, ct_data. If the sampled match was set → RESP with hit, code=ct_map_out. Otherwise → INSERT into CT.
- INSERT:
  - If dict_full → RESP with overflow=1, no write.
  - If the target is CT and ct_full → RESP with overflow=1, no write.
  - RAM target: ram_en=ram_we=1, ram_wkey=key, ram_wcode=next_code, ram_wvld=1.
  - CT target: ct_cs=ct_we=1, ct_data=key, ct_hash=hash, ct_map=next_code.
  - On a write: resp_code=next_code, resp_new=1, next_code increments.
- RESP: resp_valid=1. Hold all resp_* stable until resp_ready. → IDLE on the handshake cycle.
- next_code: HASH_WIDTH bits, reset to FIRST_CODE. dict_full=1 when next_code == 2^HASH_WIDTH-1. That value is never allocated. No wrap.
- Strobes (ram_en, ram_we, ct_cs, ct_we) are 0 in every state not listed above.
- Exactly one of resp_hit, resp_new, resp_overflow is 1 per response.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_hit=0, resp_new=0, resp_overflow=0, resp_code=0, all RAM/CT strobes 0, next_code=FIRST_CODE, dict_full=0.
- Reset mid-operation aborts the request with no write issued. A write in the same cycle as rst is suppressed.
- Latency, accept edge T to first resp_valid cycle, with resp_ready=1:
  - RAM hit: T+3.
  - RAM empty-slot insert: T+4.
  - CT hit: T+5.
  - CT insert or overflow: T+6.
- Throughput: one request per latency+1 cycles. req_ready is 0 from T+1 until after the RESP handshake.
- resp_ready held low stalls in RESP indefinitely with outputs stable.
- ct_full and dict_full are sampled in INSERT only.

## Structure
- Package lzw_pkg holds the state enum typedef dict_state_t, FIRST_CODE and the default widths. These are shared with the compressor front end.
- One sub-module is natural: lzw_code_alloc, containing the next_code counter, dict_full and the increment strobe.
- All other logic lives in lzw_dict_ctrl.

## Test plan
- Empty RAM, key 0x0141, hash 0x005 → ram write at 0x005 with code 256. Response at T+4: new=1, code=256.
- Repeat key 0x0141 → RAM hit at T+3 with code=256, no writes.
- Key 0x0142, hash 0x005 (collision), empty CT → CT write with map=257, hash=0x005. Repeat the key → hit at T+5, code=257.
- Fill the CT with 8 colliding keys, then a 9th key on the same hash → overflow=1, next_code unchanged.
- Preload next_code to 4094 and insert → code 4094, then dict_full=1. Next miss → overflow=1.
- resp_ready low for 10 cycles → resp stable and req_ready=0. Assert rst in CT_RD → IDLE, no ct_we pulse, next_code unchanged.

Source files
------------

// File: rtl/lzw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lzw_pkg
// Description : Shared constants and state type for the LZW dictionary path.
//               Also consumed by the compressor front end.
// Revision    : 1.0 - initial release
// ============================================================================
package lzw_pkg;

    localparam int DEF_DATA_WIDTH = 64;   // prefix code + byte
    localparam int DEF_HASH_WIDTH = 12;   // hash RAM address and code width
    localparam int DEF_FIRST_CODE = 256;  // codes below this are literal bytes

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAM_RD  = 3'd1,
        ST_RAM_CHK = 3'd2,
        ST_CT_Q    = 3'd3,
        ST_CT_RD   = 3'd4,
        ST_INSERT  = 3'd5,
        ST_RESP    = 3'd6
    } dict_state_t;

endpackage
`default_nettype wire

// File: rtl/lzw_dict_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lzw_dict_ctrl_if
// Description : Request/response handshake plus hash RAM and conflict table
//               buses of the dictionary controller. The master view is the
//               controller; the slave view is its surroundings.
// Revision    : 1.0 - initial release
// ============================================================================
interface lzw_dict_ctrl_if
    import lzw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int HASH_WIDTH = DEF_HASH_WIDTH
);
    // front-end request / response
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_key;
    logic [HASH_WIDTH-1:0] req_hash;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_hit;
    logic [HASH_WIDTH-1:0] resp_code;
    logic                  resp_new;
    logic                  resp_overflow;
    // hash RAM
    logic                  ram_en;
    logic                  ram_we;
    logic [HASH_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wkey;
    logic [DATA_WIDTH-1:0] ram_rkey;
    logic [HASH_WIDTH-1:0] ram_wcode;
    logic [HASH_WIDTH-1:0] ram_rcode;
    logic                  ram_wvld;
    logic                  ram_rvld;
    // conflict table
    logic                  ct_cs;
    logic                  ct_we;
    logic [DATA_WIDTH-1:0] ct_data;
    logic [HASH_WIDTH-1:0] ct_hash;
    logic [HASH_WIDTH-1:0] ct_map;
    logic                  ct_match;
    logic [HASH_WIDTH-1:0] ct_map_out;
    logic                  ct_full;
    // status
    logic                  dict_full;

    modport master (
        input  req_valid, req_key, req_hash, resp_ready,
               ram_rkey, ram_rcode, ram_rvld,
               ct_match, ct_map_out, ct_full,
        output req_ready, resp_valid, resp_hit, resp_code, resp_new, resp_overflow,
               ram_en, ram_we, ram_addr, ram_wkey, ram_wcode, ram_wvld,
               ct_cs, ct_we, ct_data, ct_hash, ct_map, dict_full
    );

    modport slave (
        output req_valid, req_key, req_hash, resp_ready,
               ram_rkey, ram_rcode, ram_rvld,
               ct_match, ct_map_out, ct_full,
        input  req_ready, resp_valid, resp_hit, resp_code, resp_new, resp_overflow,
               ram_en, ram_we, ram_addr, ram_wkey, ram_wcode, ram_wvld,
               ct_cs, ct_we, ct_data, ct_hash, ct_map, dict_full
    );

endinterface
`default_nettype wire

// File: rtl/lzw_code_alloc.sv
`default_nettype none
// ============================================================================
// Module      : lzw_code_alloc
// Description : Next-code counter for dictionary inserts. The all-ones code
//               is reserved and marks the dictionary as full; no wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module lzw_code_alloc
    import lzw_pkg::*;
#(
    parameter int HASH_WIDTH = DEF_HASH_WIDTH,
    parameter int FIRST_CODE = DEF_FIRST_CODE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_i,
    output logic [HASH_WIDTH-1:0] next_code_o,
    output logic                  dict_full_o
);

    localparam logic [HASH_WIDTH-1:0] C_FIRST = HASH_WIDTH'(FIRST_CODE);
    localparam logic [HASH_WIDTH-1:0] C_LAST  = '1;
    localparam logic [HASH_WIDTH-1:0] C_ONE   = {{(HASH_WIDTH-1){1'b0}}, 1'b1};

    logic [HASH_WIDTH-1:0] next_code_q;
    logic [HASH_WIDTH-1:0] next_code_d;

    // Advance only on a committed insert, and park on the reserved code.
    always_comb begin
        next_code_d = next_code_q;
        if (alloc_i && !dict_full_o) begin
            next_code_d = next_code_q + C_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_code_q <= C_FIRST;
        end else begin
            next_code_q <= next_code_d;
        end
    end

    assign next_code_o = next_code_q;
    assign dict_full_o = (next_code_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/lzw_dict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lzw_dict_ctrl
// Description : LZW dictionary lookup/insert sequencer. Probes the hash RAM,
//               falls back to the conflict table on a slot collision, and
//               allocates a new code on a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module lzw_dict_ctrl
    import lzw_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int HASH_WIDTH = DEF_HASH_WIDTH,
    parameter int FIRST_CODE = DEF_FIRST_CODE
) (
    input  logic            clk,
    input  logic            rst,
    lzw_dict_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_RAM_RD  = ST_RAM_RD;
    localparam logic [2:0] S_RAM_CHK = ST_RAM_CHK;
    localparam logic [2:0] S_CT_Q    = ST_CT_Q;
    localparam logic [2:0] S_CT_RD   = ST_CT_RD;
    localparam logic [2:0] S_INSERT  = ST_INSERT;
    localparam logic [2:0] S_RESP    = ST_RESP;

    logic [2:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] key_q,    key_d;
    logic [HASH_WIDTH-1:0] hash_q,   hash_d;
    logic                  ct_tgt_q, ct_tgt_d;   // insert goes to the conflict table
    logic                  ct_hit_q, ct_hit_d;   // ct_match sampled in CT_Q
    logic                  hit_q,    hit_d;
    logic                  new_q,    new_d;
    logic                  ovf_q,    ovf_d;
    logic [HASH_WIDTH-1:0] code_q,   code_d;

    logic                  ram_en_c, ram_we_c, ct_cs_c, ct_we_c, alloc_c;
    logic                  req_ready_c, resp_valid_c;
    logic [HASH_WIDTH-1:0] next_code;
    logic                  dict_full;

    lzw_code_alloc #(
        .HASH_WIDTH (HASH_WIDTH),
        .FIRST_CODE (FIRST_CODE)
    ) u_code_alloc (
        .clk         (clk),
        .rst         (rst),
        .alloc_i     (alloc_c & ~rst),
        .next_code_o (next_code),
        .dict_full_o (dict_full)
    );

    // Sequencer: next state, captured request, response fields and strobes.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        hash_d       = hash_q;
        ct_tgt_d     = ct_tgt_q;
        ct_hit_d     = ct_hit_q;
        hit_d        = hit_q;
        new_d        = new_q;
        ovf_d        = ovf_q;
        code_d       = code_q;
        ram_en_c     = 1'b0;
        ram_we_c     = 1'b0;
        ct_cs_c      = 1'b0;
        ct_we_c      = 1'b0;
        alloc_c      = 1'b0;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    key_d   = bus.req_key;
                    hash_d  = bus.req_hash;
                    state_d = S_RAM_RD;
                end
            end
            S_RAM_RD: begin
                ram_en_c = 1'b1;
                state_d  = S_RAM_CHK;
            end
            S_RAM_CHK: begin
                if (bus.ram_rvld && (bus.ram_rkey == key_q)) begin
                    hit_d   = 1'b1;
                    new_d   = 1'b0;
                    ovf_d   = 1'b0;
                    code_d  = bus.ram_rcode;
                    state_d = S_RESP;
                end else if (bus.ram_rvld) begin
                    state_d = S_CT_Q;
                end else begin
                    ct_tgt_d = 1'b0;
                    state_d  = S_INSERT;
                end
            end
            S_CT_Q: begin
                ct_cs_c  = 1'b1;
                ct_hit_d = bus.ct_match;
                state_d  = S_CT_RD;
            end
            S_CT_RD: begin
                ct_cs_c = 1'b1;
                if (ct_hit_q) begin
                    hit_d   = 1'b1;
                    new_d   = 1'b0;
                    ovf_d   = 1'b0;
                    code_d  = bus.ct_map_out;
                    state_d = S_RESP;
                end else begin
                    ct_tgt_d = 1'b1;
                    state_d  = S_INSERT;
                end
            end
            S_INSERT: begin
                hit_d   = 1'b0;
                state_d = S_RESP;
                if (dict_full || (ct_tgt_q && bus.ct_full)) begin
                    new_d  = 1'b0;
                    ovf_d  = 1'b1;
                    code_d = '0;
                end else begin
                    ram_en_c = ~ct_tgt_q;
                    ram_we_c = ~ct_tgt_q;
                    ct_cs_c  = ct_tgt_q;
                    ct_we_c  = ct_tgt_q;
                    alloc_c  = 1'b1;
                    new_d    = 1'b1;
                    ovf_d    = 1'b0;
                    code_d   = next_code;
                end
            end
            S_RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            hash_q   <= '0;
            ct_tgt_q <= 1'b0;
            ct_hit_q <= 1'b0;
            hit_q    <= 1'b0;
            new_q    <= 1'b0;
            ovf_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            hash_q   <= hash_d;
            ct_tgt_q <= ct_tgt_d;
            ct_hit_q <= ct_hit_d;
            hit_q    <= hit_d;
            new_q    <= new_d;
            ovf_q    <= ovf_d;
            code_q   <= code_d;
        end
    end

    // Strobes are masked by rst so a write coinciding with reset never lands.
    assign bus.ram_en        = ram_en_c & ~rst;
    assign bus.ram_we        = ram_we_c & ~rst;
    assign bus.ct_cs         = ct_cs_c  & ~rst;
    assign bus.ct_we         = ct_we_c  & ~rst;
    assign bus.ram_addr      = hash_q;
    assign bus.ram_wkey      = key_q;
    assign bus.ram_wcode     = next_code;
    assign bus.ram_wvld      = 1'b1;
    assign bus.ct_data       = key_q;
    assign bus.ct_hash       = hash_q;
    assign bus.ct_map        = next_code;
    assign bus.req_ready     = req_ready_c;
    assign bus.resp_valid    = resp_valid_c;
    assign bus.resp_hit      = hit_q;
    assign bus.resp_new      = new_q;
    assign bus.resp_overflow = ovf_q;
    assign bus.resp_code     = code_q;
    assign bus.dict_full     = dict_full;

endmodule
`default_nettype wire

// File: tb/tb_lzw_dict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lzw_dict_ctrl
// Description : Self-checking bench for lzw_dict_ctrl with behavioural hash RAM
//               and conflict table, and a dictionary-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lzw_dict_ctrl;
    import lzw_pkg::*;

    localparam int DW       = 64;
    localparam int HW       = 12;
    localparam int NSLOT    = 4096;
    localparam int LAST     = 4095;
    localparam int CT_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lzw_dict_ctrl_if #(.DATA_WIDTH(DW), .HASH_WIDTH(HW)) bus ();

    lzw_dict_ctrl #(.DATA_WIDTH(DW), .HASH_WIDTH(HW), .FIRST_CODE(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- hash RAM environment (1-cycle read latency) ----------
    logic [DW-1:0] mem_key  [NSLOT];
    logic [HW-1:0] mem_code [NSLOT];
    logic          mem_vld  [NSLOT];
    logic          mem_clr = 1'b1;
    int            ram_wr_cnt = 0;
    int            ct_wr_cnt  = 0;

    always @(posedge clk) begin
        if (bus.ram_en && bus.ram_we) ram_wr_cnt <= ram_wr_cnt + 1;
        if (mem_clr) begin
            for (int i = 0; i < NSLOT; i++) mem_vld[i] <= 1'b0;
        end else if (bus.ram_en && bus.ram_we) begin
            mem_key[bus.ram_addr]  <= bus.ram_wkey;
            mem_code[bus.ram_addr] <= bus.ram_wcode;
            mem_vld[bus.ram_addr]  <= bus.ram_wvld;
        end else if (bus.ram_en) begin
            bus.ram_rkey  <= mem_key[bus.ram_addr];
            bus.ram_rcode <= mem_code[bus.ram_addr];
            bus.ram_rvld  <= mem_vld[bus.ram_addr];
        end
    end

    // ---------------- conflict table environment ----------------------------
    logic [DW-1:0] ctm_key  [CT_DEPTH];
    logic [HW-1:0] ctm_code [CT_DEPTH];
    logic [HW-1:0] ctm_hash [CT_DEPTH];
    int            ct_cnt = 0;

    always @(posedge clk) begin
        if (bus.ct_cs && bus.ct_we) ct_wr_cnt <= ct_wr_cnt + 1;
        if (mem_clr) begin
            ct_cnt <= 0;
        end else if (bus.ct_cs && bus.ct_we) begin
            if (ct_cnt < CT_DEPTH) begin
                ctm_key[ct_cnt]  <= bus.ct_data;
                ctm_code[ct_cnt] <= bus.ct_map;
                ctm_hash[ct_cnt] <= bus.ct_hash;
                ct_cnt           <= ct_cnt + 1;
            end
        end else if (bus.ct_cs) begin
            for (int i = 0; i < CT_DEPTH; i++)
                if (i < ct_cnt && ctm_key[i] == bus.ct_data) bus.ct_map_out <= ctm_code[i];
        end
    end

    always_comb begin
        bus.ct_match = 1'b0;
        for (int i = 0; i < CT_DEPTH; i++)
            if (i < ct_cnt && bus.ct_cs && ctm_key[i] == bus.ct_data) bus.ct_match = 1'b1;
    end

    assign bus.ct_full = (ct_cnt == CT_DEPTH);

    // ---------------- reference model: dictionary contents -----------------
    bit            m_vld  [NSLOT];
    logic [DW-1:0] m_key  [NSLOT];
    int            m_code [NSLOT];
    logic [DW-1:0] m_ctk  [$];
    int            m_ctc  [$];
    int            m_next;

    task automatic model_clear();
        for (int i = 0; i < NSLOT; i++) m_vld[i] = 1'b0;
        m_ctk.delete();
        m_ctc.delete();
        m_next = 256;
    endtask

    // ---------------- checking -----------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_reset_values();
        chk("rst_req_ready",  64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_hit",   64'(bus.resp_hit), 64'd0);
        chk("rst_resp_new",   64'(bus.resp_new), 64'd0);
        chk("rst_resp_ovf",   64'(bus.resp_overflow), 64'd0);
        chk("rst_resp_code",  64'(bus.resp_code), 64'd0);
        chk("rst_strobes",    64'({bus.ram_en, bus.ram_we, bus.ct_cs, bus.ct_we}), 64'd0);
        chk("rst_dict_full",  64'(bus.dict_full), 64'd0);
    endtask

    // Full reset that also empties the RAM/CT and the model.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        mem_clr = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        mem_clr = 1'b0;
        model_clear();
        check_idle_reset_values();
    endtask

    // One request: predict from the model, run it, compare everything.
    task automatic do_req(input logic [DW-1:0] key, input logic [HW-1:0] hash, input int stall);
        bit e_hit, e_new, e_ovf, ram_tgt, ct_tgt, found;
        int e_code, lat, n, rw0, cw0;
        e_hit = 0; e_new = 0; e_ovf = 0; ram_tgt = 0; ct_tgt = 0; e_code = 0; found = 0;
        if (m_vld[hash] && m_key[hash] == key) begin
            e_hit = 1; e_code = m_code[hash]; lat = 3;
        end else if (m_vld[hash]) begin
            for (int i = 0; i < m_ctk.size(); i++)
                if (m_ctk[i] == key) begin found = 1; e_code = m_ctc[i]; end
            if (found) begin
                e_hit = 1; lat = 5;
            end else begin
                lat = 6;
                if (m_next == LAST || m_ctk.size() == CT_DEPTH) e_ovf = 1;
                else begin
                    e_new = 1; ct_tgt = 1; e_code = m_next;
                    m_ctk.push_back(key); m_ctc.push_back(m_next); m_next++;
                end
            end
        end else begin
            lat = 4;
            if (m_next == LAST) e_ovf = 1;
            else begin
                e_new = 1; ram_tgt = 1; e_code = m_next;
                m_vld[hash] = 1; m_key[hash] = key; m_code[hash] = m_next; m_next++;
            end
        end
        rw0 = ram_wr_cnt;
        cw0 = ct_wr_cnt;
        @(negedge clk);
        bus.req_key = key; bus.req_hash = hash; bus.req_valid = 1'b1; bus.resp_ready = 1'b0;
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
        // cycle T+k begins at the (k-1)th edge after the accept edge
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 64'(n), 64'(lat - 1));
        chk("resp_flags", 64'({bus.resp_hit, bus.resp_new, bus.resp_overflow}), 64'({e_hit, e_new, e_ovf}));
        chk("resp_code", 64'(bus.resp_code), 64'(e_code));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("stall_hold",
                64'({bus.resp_valid, bus.req_ready, bus.resp_hit, bus.resp_new, bus.resp_overflow, bus.resp_code}),
                64'({1'b1, 1'b0, e_hit, e_new, e_ovf, HW'(e_code)}));
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        chk("resp_done", 64'({bus.resp_valid, bus.req_ready}), 64'(2'b01));
        chk("ram_writes", 64'(ram_wr_cnt - rw0), 64'(ram_tgt));
        chk("ct_writes", 64'(ct_wr_cnt - cw0), 64'(ct_tgt));
        chk("dict_full", 64'(bus.dict_full), 64'(m_next == LAST));
        if (ram_tgt) begin
            chk("ram_key",  mem_key[hash], key);
            chk("ram_code", 64'(mem_code[hash]), 64'(e_code));
        end
        if (ct_tgt && ct_cnt > 0) begin
            chk("ct_hash", 64'(ctm_hash[ct_cnt-1]), 64'(hash));
            chk("ct_map",  64'(ctm_code[ct_cnt-1]), 64'(e_code));
        end
    endtask

    logic [DW-1:0] pool [24];
    int            rw0, cw0, pidx;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_key    = '0;
        bus.req_hash   = '0;
        bus.resp_ready = 1'b0;
        model_clear();

        do_reset();

        // RAM insert, RAM hit, CT insert, CT hit, stalled response
        do_req(64'h0141, 12'h005, 0);
        do_req(64'h0141, 12'h005, 0);
        do_req(64'h0142, 12'h005, 0);
        do_req(64'h0142, 12'h005, 0);
        do_req(64'h0141, 12'h005, 10);

        // reset while in CT_RD: no CT write, controller back in IDLE
        @(negedge clk);
        bus.req_key = 64'h0143; bus.req_hash = 12'h005; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        cw0 = ct_wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("ctrd_strobes", 64'({bus.ct_cs, bus.ct_we}), 64'(2'b10));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("ctrd_rst_no_write", 64'(ct_wr_cnt - cw0), 64'd0);
        chk("ctrd_rst_idle", 64'({bus.req_ready, bus.resp_valid, bus.dict_full}), 64'(3'b100));
        do_reset();

        // reset during INSERT: the RAM write is suppressed, code not consumed
        @(negedge clk);
        bus.req_key = 64'h0200; bus.req_hash = 12'h009; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rw0 = ram_wr_cnt;
        repeat (2) @(posedge clk);
        #1;
        chk("ins_strobes", 64'({bus.ram_en, bus.ram_we}), 64'(2'b11));
        rst = 1'b1;
        #1;
        chk("ins_rst_mask", 64'({bus.ram_en, bus.ram_we}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("ins_rst_no_write", 64'(ram_wr_cnt - rw0), 64'd0);
        do_req(64'h0200, 12'h009, 0);

        // fill the CT on one hash, then overflow, then an unrelated insert
        do_req(64'h0300, 12'h007, 0);
        for (int i = 0; i < CT_DEPTH + 1; i++)
            do_req({32'($urandom), 32'(i + 1)} | 64'h1000_0000, 12'h007, 0);
        do_req(64'h0400, 12'h008, 0);
        do_req(64'h0300, 12'h007, 1);

        // randomized traffic over a small key pool with colliding hashes
        do_reset();
        for (int i = 0; i < 24; i++) pool[i] = {32'($urandom), 24'($urandom), 8'(i + 1)};
        for (int r = 0; r < 150; r++) begin
            pidx = int'($urandom_range(0, 23));
            do_req(pool[pidx], HW'(pidx % 5), int'($urandom_range(0, 2)));
        end

        // exhaust the code space: 256..4093 into distinct slots, then 4094
        do_reset();
        for (int i = 0; i < 3838; i++) do_req(64'h1_0000 + 64'(i), HW'(i), 0);
        do_req(64'h2_0000, 12'd3838, 0);
        chk("dict_full_set", 64'(bus.dict_full), 64'd1);
        do_req(64'h2_0001, 12'd3839, 0);
        do_req(64'h2_0002, 12'd0, 0);
        do_req(64'h1_0005, 12'd5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
